cmn_demux_router: RTL and testbench
===================================

Name: cmn_demux_router

Overview:
- Packet-aware stream router that drives a 1-to-N demux datapath from a single val/rdy input stream.
- The destination is taken from the first beat of each packet and locked until the beat flagged last is accepted.
- Beats pass through a one-entry output register, so full throughput is sustained when the selected consumer is ready.
- Sits between a shared producer (e.g. a SPI/crossbar front end) and N independent consumers; it also counts misrouted packets.

Parameters:
- nbits, 8, message width in bits.
- noutputs, 4, number of output ports (>= 2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- recv_msg  in  nbits  input beat payload.
- recv_sel  in  $clog2(noutputs)  destination; sampled only on the first beat of a packet.
- recv_last  in  1  marks the final beat of a packet.
- recv_val  in  1  input beat valid.
- recv_rdy  out  1  router can accept a beat this cycle.
- send_msg  out  nbits x noutputs (unpacked [0:noutputs-1])  per-output payload.
- send_val  out  noutputs  per-output valid.
- send_rdy  in  noutputs  per-output ready.
- pkt_active  out  1  a multi-beat packet is in progress (destination locked).
- drop_count  out  8  saturating count of dropped packets.

Behaviour:
- Handshake:
  - A transfer occurs on any cycle where val and rdy are both high.
  - Producers may not withdraw val once it is asserted.
- Reset (asynchronous, immediate):
  - buffer empty; state IDLE; lock_dst = 0; drop_count = 0.
  - Outputs during reset: send_val all 0, send_msg all 0, recv_rdy 1, pkt_active 0.
  - Reset mid-packet discards the buffered beat and the lock; the next accepted beat is treated as a packet head.
- Output register (buf_msg, buf_dst, buf_full):
  - send_val[i] = buf_full && (buf_dst == i).
  - send_msg[i] = buf_msg when i == buf_dst and buf_full; otherwise all zeros.
  - recv_rdy = !buf_full || send_rdy[buf_dst].
  - Consequences: a one-entry pipeline; drain and fill in the same cycle are allowed; no bubble under continuous ready.
  - Latency: a beat accepted in cycle t is presented on send_* in cycle t+1.
  - Ready on non-selected outputs is ignored.
- State machine:
  - IDLE:
    - Accepted beat uses dst = recv_sel.
    - If recv_last = 0, capture lock_dst = dst and go to PKT.
    - If recv_last = 1, stay in IDLE (single-beat packet).
  - PKT:
    - Accepted beat uses dst = lock_dst; recv_sel is ignored.
    - recv_last = 1 on an accepted beat returns the FSM to IDLE.
    - No transition occurs without an accepted beat.
  - pkt_active = (state == PKT).
- Invalid destination (recv_sel >= noutputs on a head beat; possible only when noutputs is not a power of 2):
  - The whole packet is dropped.
  - The head beat and all beats up to and including last are accepted (recv_rdy = 1 for them, independent of buffer state) and never enter the buffer.
  - The FSM uses PKT with a drop flag set; pkt_active = 1 during the drop.
  - drop_count increments by 1 when the head is accepted and saturates at 255.
  - A beat already in the buffer continues to drain normally.
- The router does not reorder or duplicate beats; every accepted non-dropped beat appears exactly once, in order.

Test Plan:
- Basic routing:
  - Stimulus: after reset, noutputs=4, send_rdy=4'b1111; single-beat packets msg 0x11/0x22/0x33/0x44 with sel 0/1/2/3 and last=1 on consecutive cycles.
  - Required: each msg appears on send_val[sel] one cycle after acceptance; non-selected send_msg = 0; recv_rdy stays 1.
- Destination lock:
  - Stimulus: 3-beat packet 0xA0, 0xA1, 0xA2; sel=2 on the head, sel=0/1 on the body beats; last on the third beat.
  - Required: all three beats on output 2; pkt_active = 1 after beat 1 and 0 after beat 3; next head with sel=1 routes to output 1.
- Backpressure:
  - Stimulus: send_rdy[1]=0 with beats for output 1 (msg 0x55, then 0x66).
  - Required: 0x55 held stable on send_msg[1] with send_val[1]=1; recv_rdy=0 while 0x66 is pending.
  - Required on raising send_rdy[1]: 0x55 and 0x66 drain on consecutive cycles with no bubble; send_rdy[0]=1 has no effect.
- Same-cycle drain and fill:
  - Stimulus: continuous val, send_rdy all 1, 16 beats to alternating outputs.
  - Required: 16 beats delivered in 16 consecutive cycles after a 1-cycle latency.
- Invalid destination:
  - Stimulus: noutputs=3; 2-beat packet with sel=3 (0xEE, 0xEF), then 300 single-beat packets with sel=3.
  - Required: no send_val asserted for these beats; drop_count = 1 after the first packet and saturates at 255.
  - Required: a following packet with sel=0 is delivered normally.
- Reset mid-packet:
  - Stimulus: assert reset asynchronously while in PKT with a beat buffered.
  - Required: send_val drops to 0 immediately, without waiting for a clock edge; pkt_active = 0; drop_count = 0.
  - Required: after reset release, the next beat's recv_sel is honoured as a head.

Source files
------------

// File: rtl/cmn_demux_router.sv
// Packet-locked 1-to-N stream demux with a one-entry output register and a saturating drop counter.
// Latency 1 cycle; recv_rdy follows the locked output's send_rdy, beats of dropped packets are always accepted.
module cmn_demux_router #(
   parameter int nbits    = 8,
   parameter int noutputs = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [nbits-1:0]            recv_msg,
   input  logic [$clog2(noutputs)-1:0] recv_sel,
   input  logic                        recv_last,
   input  logic                        recv_val,
   output logic                        recv_rdy,
   output logic [nbits-1:0]            send_msg [0:noutputs-1],
   output logic [noutputs-1:0]         send_val,
   input  logic [noutputs-1:0]         send_rdy,
   output logic                        pkt_active,
   output logic [7:0]                  drop_count
);
   localparam int selw = $clog2(noutputs);

   typedef enum logic {IDLE, PKT} state_t;

   typedef struct packed {
      logic [nbits-1:0] msg;
      logic [selw-1:0]  dst;
   } beat_t;

   state_t          state, state_nxt;
   logic [selw-1:0] lock_dst, lock_dst_nxt;
   logic            drop_flag, drop_flag_nxt;
   beat_t           buf_dat;
   logic            buf_full;

   logic            sel_ok;
   logic            drain;
   logic            dropping;
   logic            accept;
   logic            load;
   logic            head_drop;
   logic [selw-1:0] cur_dst;

   // Out-of-range selects only exist when noutputs is not a power of two.
   generate
      if ((1 << selw) == noutputs) begin : g_pow2
         assign sel_ok = 1'b1;
      end else begin : g_npow2
         assign sel_ok = ({1'b0, recv_sel} < (selw+1)'(noutputs));
      end
   endgenerate

   always_comb begin
      send_val = '0;
      for (int i = 0; i < noutputs; i++) begin
         send_msg[i] = '0;
      end
      for (int i = 0; i < noutputs; i++) begin
         send_val[i] = buf_full && (buf_dat.dst == selw'(i));
         send_msg[i] = send_val[i] ? buf_dat.msg : '0;
      end
   end

   // send_val is one-hot on buf_dst, so readiness of unselected outputs cannot leak in.
   always_comb begin
      drain     = |(send_val & send_rdy);
      dropping  = (state == PKT) ? drop_flag : !sel_ok;
      recv_rdy  = dropping || !buf_full || drain;
      accept    = recv_val && recv_rdy;
      load      = accept && !dropping;
      head_drop = accept && (state == IDLE) && !sel_ok;
      cur_dst   = (state == PKT) ? lock_dst : recv_sel;
   end

   assign pkt_active = (state == PKT);

   always_comb begin
      state_nxt     = state;
      lock_dst_nxt  = lock_dst;
      drop_flag_nxt = drop_flag;
      if (accept) begin
         case (state)
            IDLE: begin
               if (!recv_last) begin
                  state_nxt     = PKT;
                  lock_dst_nxt  = recv_sel;
                  drop_flag_nxt = !sel_ok;
               end
            end
            PKT: begin
               if (recv_last) begin
                  state_nxt     = IDLE;
                  drop_flag_nxt = 1'b0;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         lock_dst  <= '0;
         drop_flag <= 1'b0;
      end else begin
         state     <= state_nxt;
         lock_dst  <= lock_dst_nxt;
         drop_flag <= drop_flag_nxt;
      end
   end

   // A new beat may overwrite the one draining in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_full <= 1'b0;
         buf_dat  <= '0;
      end else if (load) begin
         buf_full    <= 1'b1;
         buf_dat.msg <= recv_msg;
         buf_dat.dst <= cur_dst;
      end else if (drain) begin
         buf_full <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_count <= '0;
      end else if (head_drop && (drop_count != 8'hFF)) begin
         drop_count <= drop_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_cmn_demux_router.sv
// Bench for cmn_demux_router: a 4-output and a 3-output instance checked every cycle against a queue model.
module tb_cmn_demux_router;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [1:0][7:0] rmsg;
   logic [1:0][1:0] rsel;
   logic [1:0]      rlast;
   logic [1:0]      rval;
   logic [1:0][3:0] srdy;

   logic       rrdy4, rrdy3;
   logic [7:0] smsg4 [0:3];
   logic [7:0] smsg3 [0:2];
   logic [3:0] sval4;
   logic [2:0] sval3;
   logic       pact4, pact3;
   logic [7:0] dcnt4, dcnt3;

   cmn_demux_router #(.nbits(8), .noutputs(4)) dut4 (
      .clk(clk), .reset(reset), .recv_msg(rmsg[0]), .recv_sel(rsel[0]), .recv_last(rlast[0]),
      .recv_val(rval[0]), .recv_rdy(rrdy4), .send_msg(smsg4), .send_val(sval4), .send_rdy(srdy[0]),
      .pkt_active(pact4), .drop_count(dcnt4));

   cmn_demux_router #(.nbits(8), .noutputs(3)) dut3 (
      .clk(clk), .reset(reset), .recv_msg(rmsg[1]), .recv_sel(rsel[1]), .recv_last(rlast[1]),
      .recv_val(rval[1]), .recv_rdy(rrdy3), .send_msg(smsg3), .send_val(sval3), .send_rdy(srdy[1][2:0]),
      .pkt_active(pact3), .drop_count(dcnt3));

   // Reference model: per-output queues of beats not yet taken by the consumer.
   logic [7:0] mq [8][$];
   bit  in_pkt [2];
   bit  pkt_drop [2];
   int  pkt_dst [2];
   int  drops [2];
   bit  exp_rdy [2];
   bit  acc [2];
   int  n_checks = 0;
   int  n_pass = 0;
   int  n_fail = 0;
   int  cycle = 0;

   function automatic int nout(int d);
      return (d == 0) ? 4 : 3;
   endfunction

   function automatic logic [3:0] get_val(int d);
      return (d == 0) ? sval4 : {1'b0, sval3};
   endfunction

   function automatic logic [7:0] get_msg(int d, int i);
      if (d == 0) return smsg4[i[1:0]];
      if (i < 3) return smsg3[i[1:0]];
      return 8'h00;
   endfunction

   function automatic logic get_pact(int d);
      return (d == 0) ? pact4 : pact3;
   endfunction

   function automatic logic get_rrdy(int d);
      return (d == 0) ? rrdy4 : rrdy3;
   endfunction

   function automatic logic [7:0] get_dcnt(int d);
      return (d == 0) ? dcnt4 : dcnt3;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic reset_model();
      for (int q = 0; q < 8; q++) mq[q].delete();
      for (int d = 0; d < 2; d++) begin
         in_pkt[d] = 0; pkt_drop[d] = 0; pkt_dst[d] = 0; drops[d] = 0; acc[d] = 0; exp_rdy[d] = 1;
      end
   endtask

   task automatic check_dut(int d);
      int       n;
      logic [3:0] ev;
      bit       busy;
      int       odst;
      bit       drop_next;
      n = nout(d); ev = '0; busy = 0; odst = 0;
      for (int i = 0; i < n; i++) begin
         if (mq[d*4+i].size() > 0) begin
            ev[i] = 1'b1; busy = 1; odst = i;
         end
      end
      chk($sformatf("d%0d send_val", d), 32'(get_val(d)), 32'(ev));
      for (int i = 0; i < n; i++)
         chk($sformatf("d%0d send_msg[%0d]", d, i), 32'(get_msg(d, i)), ev[i] ? 32'(mq[d*4+i][0]) : 32'h0);
      chk($sformatf("d%0d pkt_active", d), 32'(get_pact(d)), 32'(in_pkt[d]));
      chk($sformatf("d%0d drop_count", d), 32'(get_dcnt(d)), (drops[d] > 255) ? 32'd255 : 32'(drops[d]));
      drop_next = in_pkt[d] ? pkt_drop[d] : (int'(rsel[d]) >= n);
      exp_rdy[d] = drop_next || !busy || srdy[d][odst];
      chk($sformatf("d%0d recv_rdy", d), 32'(get_rrdy(d)), 32'(exp_rdy[d]));
   endtask

   task automatic model_step(int d);
      int n;
      int dst;
      bit drop;
      n = nout(d);
      acc[d] = 0;
      for (int i = 0; i < n; i++)
         if (mq[d*4+i].size() > 0 && srdy[d][i]) void'(mq[d*4+i].pop_front());
      if (rval[d] && exp_rdy[d]) begin
         acc[d] = 1;
         if (!in_pkt[d]) begin
            dst  = int'(rsel[d]);
            drop = (dst >= n);
            if (drop) drops[d]++;
            if (!rlast[d]) begin
               in_pkt[d] = 1; pkt_dst[d] = dst; pkt_drop[d] = drop;
            end
         end else begin
            dst  = pkt_dst[d];
            drop = pkt_drop[d];
            if (rlast[d]) in_pkt[d] = 0;
         end
         if (!drop) mq[d*4+dst].push_back(rmsg[d]);
      end
   endtask

   // Called at the falling edge after inputs are driven; returns at the next falling edge.
   task automatic tick();
      #1;
      check_dut(0); check_dut(1);
      model_step(0); model_step(1);
      @(posedge clk);
      cycle++;
      @(negedge clk);
   endtask

   task automatic send_beat(int d, logic [7:0] m, logic [1:0] s, logic l);
      int waited;
      waited = 0;
      rval[d] = 1'b1; rmsg[d] = m; rsel[d] = s; rlast[d] = l;
      tick();
      while (!acc[d] && waited < 50) begin
         tick();
         waited++;
      end
      chk($sformatf("d%0d beat 0x%0h accepted", d, m), 32'(acc[d]), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int start;
      reset = 1'b1;
      rval = '0; rmsg = '0; rsel = '0; rlast = '0; srdy = '1;
      reset_model();
      #2;
      check_dut(0); check_dut(1);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;

      // Basic routing: one single-beat packet per output, no stalls
      start = cycle;
      for (int k = 0; k < 4; k++) send_beat(0, 8'(8'h11 * (k + 1)), 2'(k), 1'b1);
      chk("basic cycles", 32'(cycle - start), 32'd4);
      chk("basic last val", 32'(sval4), 32'b1000);
      chk("basic last msg", 32'(smsg4[3]), 32'h44);
      rval[0] = 1'b0;
      tick();

      // Destination lock
      send_beat(0, 8'hA0, 2'd2, 1'b0);
      chk("lock active", 32'(pact4), 32'd1);
      send_beat(0, 8'hA1, 2'd0, 1'b0);
      chk("lock body1 val", 32'(sval4), 32'b0100);
      send_beat(0, 8'hA2, 2'd1, 1'b1);
      chk("lock released", 32'(pact4), 32'd0);
      chk("lock tail msg", 32'(smsg4[2]), 32'hA2);
      send_beat(0, 8'hB1, 2'd1, 1'b1);
      chk("lock next head", 32'(sval4), 32'b0010);
      rval[0] = 1'b0;
      tick();

      // Backpressure on output 1 with output 0 ready
      srdy[0] = 4'b1101;
      send_beat(0, 8'h55, 2'd1, 1'b1);
      rmsg[0] = 8'h66; rsel[0] = 2'd1; rlast[0] = 1'b1; rval[0] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("bp rdy low", 32'(rrdy4), 32'd0);
         chk("bp held msg", 32'(smsg4[1]), 32'h55);
      end
      srdy[0] = 4'b1111;
      tick();
      chk("bp accepted on release", 32'(acc[0]), 32'd1);
      chk("bp no bubble", 32'(smsg4[1]), 32'h66);
      rval[0] = 1'b0;
      tick();
      chk("bp drained", 32'(sval4), 32'd0);

      // Same-cycle drain and fill
      start = cycle;
      for (int k = 0; k < 16; k++) send_beat(0, 8'(8'h80 + k), 2'((k % 2) * 2), 1'b1);
      chk("stream cycles", 32'(cycle - start), 32'd16);
      rval[0] = 1'b0;
      tick(); tick();

      // Invalid destination on the 3-output instance
      send_beat(1, 8'hEE, 2'd3, 1'b0);
      chk("drop active", 32'(pact3), 32'd1);
      send_beat(1, 8'hEF, 2'd0, 1'b1);
      chk("drop inactive", 32'(pact3), 32'd0);
      chk("drop no val", 32'(sval3), 32'd0);
      chk("drop count 1", 32'(dcnt3), 32'd1);
      for (int k = 0; k < 300; k++) send_beat(1, 8'(k), 2'd3, 1'b1);
      chk("drop saturated", 32'(dcnt3), 32'd255);
      send_beat(1, 8'h5A, 2'd0, 1'b1);
      chk("after drop val", 32'(sval3), 32'b001);
      chk("after drop msg", 32'(smsg3[0]), 32'h5A);
      rval[1] = 1'b0;
      tick();

      // Randomized traffic on both instances
      for (int c = 0; c < 1500; c++) begin
         for (int d = 0; d < 2; d++) begin
            if (!(rval[d] && !acc[d])) begin
               rval[d]  = ($urandom % 4) != 0;
               rmsg[d]  = 8'($urandom);
               rlast[d] = ($urandom % 3) == 0;
               if (d == 0) rsel[d] = 2'($urandom % 4);
               else        rsel[d] = (($urandom % 8) == 0) ? 2'd3 : 2'($urandom % 3);
            end
            srdy[d] = 4'($urandom);
         end
         tick();
      end
      for (int d = 0; d < 2; d++) begin
         srdy[d] = 4'b1111;
         if (rval[d] && !acc[d]) begin
            tick();
            while (rval[d] && !acc[d] && cycle < 60000) tick();
         end
         if (in_pkt[d]) send_beat(d, 8'hF0, 2'd0, 1'b1);
         rval[d] = 1'b0;
      end
      tick(); tick();

      // Asynchronous reset mid-packet with a beat buffered
      srdy[0] = 4'b0111;
      send_beat(0, 8'hC0, 2'd3, 1'b0);
      rmsg[0] = 8'hC1; rsel[0] = 2'd0; rlast[0] = 1'b1; rval[0] = 1'b1;
      tick();
      chk("pre-reset active", 32'(pact4), 32'd1);
      chk("pre-reset val", 32'(sval4), 32'b1000);
      #2;
      reset = 1'b1;
      #1;
      chk("async reset val", 32'(sval4), 32'd0);
      chk("async reset msg", 32'(smsg4[3]), 32'd0);
      chk("async reset active", 32'(pact4), 32'd0);
      chk("async reset rdy", 32'(rrdy4), 32'd1);
      chk("async reset drops", 32'(dcnt3), 32'd0);
      rval = '0;
      reset_model();
      @(negedge clk);
      reset = 1'b0;
      srdy = '1;
      send_beat(0, 8'hD1, 2'd1, 1'b1);
      chk("post-reset head val", 32'(sval4), 32'b0010);
      chk("post-reset head msg", 32'(smsg4[1]), 32'hD1);
      rval[0] = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
